// File: rtl/stack_mem_xfer_pkg.sv
// Shared opcodes, error codes and FSM state encoding for the stack/memory transfer engine.
package stack_mem_xfer_pkg;

  localparam logic [2:0] OPC_PUSHI  = 3'd0;
  localparam logic [2:0] OPC_LOAD   = 3'd1;
  localparam logic [2:0] OPC_STORE  = 3'd2;
  localparam logic [2:0] OPC_LOADI  = 3'd3;
  localparam logic [2:0] OPC_STOREI = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_UNDER   = 2'd2;
  localparam logic [1:0] ERR_OVER    = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StPopA,
    StPopD,
    StRd,
    StRdWait,
    StPush,
    StWr,
    StDone
  } xfer_state_e;

endpackage

// File: rtl/xfer_lat_cnt.sv
// Loadable down-counter that times the memory read latency; expired marks the data-valid cycle.
module xfer_lat_cnt #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_RD_LAT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(MEM_RD_LAT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count of 1 is the last wait cycle: read data is valid now.
  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/stack_mem_xfer.sv
// Stack/memory transfer engine: one push/load/store/indirect op per accepted command.
module stack_mem_xfer
  import stack_mem_xfer_pkg::*;
#(
  parameter int unsigned ADDR_LEN   = 8,
  parameter int unsigned DATA_LEN   = 8,
  parameter int unsigned STK_DEPTH  = 16,
  parameter int unsigned MEM_RD_LAT = 1,
  localparam int unsigned CNT_W     = $clog2(STK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_opc,
  input  logic [DATA_LEN-1:0] addr_const,
  output logic                cmd_ready,
  output logic                done,
  output logic [1:0]          err,
  input  logic [CNT_W-1:0]    stk_count,
  input  logic [DATA_LEN-1:0] stk_data_out,
  output logic                stk_push,
  output logic                stk_pop,
  output logic [DATA_LEN-1:0] stk_data_in,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [DATA_LEN-1:0] mem_data_in,
  input  logic [DATA_LEN-1:0] mem_data_out
);

  xfer_state_e         state_q, state_d;
  logic [2:0]          opc_q, opc_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_LEN-1:0] stk_din_q, stk_din_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_LEN-1:0] mem_din_q, mem_din_d;
  logic [1:0]          acc_err;
  logic                lat_load, lat_dec, lat_expired;

  xfer_lat_cnt #(
    .MEM_RD_LAT (MEM_RD_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .load    (lat_load),
    .dec     (lat_dec),
    .expired (lat_expired)
  );

  always_comb begin
    acc_err = ERR_NONE;
    if (cmd_opc > OPC_STOREI) begin
      acc_err = ERR_ILLEGAL;
    end else if ((((cmd_opc == OPC_STORE) || (cmd_opc == OPC_LOADI)) && (stk_count == '0)) ||
                 ((cmd_opc == OPC_STOREI) && (stk_count < CNT_W'(2)))) begin
      acc_err = ERR_UNDER;
    end else if (((cmd_opc == OPC_PUSHI) || (cmd_opc == OPC_LOAD)) &&
                 (stk_count == CNT_W'(STK_DEPTH))) begin
      acc_err = ERR_OVER;
    end
  end

  assign cmd_ready = (state_q == StIdle) && en;

  // Data/address outputs are only reloaded on entry to their strobe state so they hold otherwise.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    addr_d     = addr_q;
    err_d      = err_q;
    stk_din_d  = stk_din_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    lat_load   = 1'b0;
    lat_dec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          opc_d  = cmd_opc;
          addr_d = addr_const;
          err_d  = acc_err;
          if (acc_err != ERR_NONE) begin
            state_d = StDone;
          end else begin
            case (cmd_opc)
              OPC_PUSHI: begin
                state_d   = StPush;
                stk_din_d = addr_const;
              end
              OPC_LOAD: begin
                state_d    = StRd;
                mem_addr_d = addr_const[ADDR_LEN-1:0];
              end
              OPC_STORE:  state_d = StPopD;
              default:    state_d = StPopA;
            endcase
          end
        end
      end
      StPopA: begin
        addr_d = stk_data_out;
        if (opc_q == OPC_LOADI) begin
          state_d    = StRd;
          mem_addr_d = stk_data_out[ADDR_LEN-1:0];
        end else begin
          state_d = StPopD;
        end
      end
      StPopD: begin
        state_d    = StWr;
        mem_addr_d = addr_q[ADDR_LEN-1:0];
        mem_din_d  = stk_data_out;
      end
      StRd: begin
        state_d  = StRdWait;
        lat_load = 1'b1;
      end
      StRdWait: begin
        lat_dec = 1'b1;
        if (lat_expired) begin
          state_d   = StPush;
          stk_din_d = mem_data_out;
        end
      end
      StPush, StWr, StDone: state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      opc_q      <= '0;
      addr_q     <= '0;
      err_q      <= ERR_NONE;
      stk_din_q  <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      stk_din_q  <= stk_din_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign stk_push    = (state_q == StPush);
  assign stk_pop     = (state_q == StPopA) || (state_q == StPopD);
  assign mem_r_en    = (state_q == StRd);
  assign mem_w_en    = (state_q == StWr);
  assign done        = (state_q == StPush) || (state_q == StWr) || (state_q == StDone);
  assign err         = (state_q == StDone) ? err_q : ERR_NONE;
  assign stk_data_in = stk_din_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_din_q;

endmodule

// File: tb/tb_stack_mem_xfer.sv
// Bench for stack_mem_xfer: bench-side stack/memory plus a transaction-level reference model.
module tb_stack_mem_xfer;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic       clk = 1'b0;
  logic       rstn, en, cmd_valid;
  logic [2:0] cmd_opc;
  logic [7:0] addr_const, stk_data_out, stk_data_in, mem_addr, mem_data_in, mem_data_out;
  logic       cmd_ready, done, stk_push, stk_pop, mem_r_en, mem_w_en;
  logic [1:0] err;
  logic [CW-1:0] stk_count;

  stack_mem_xfer #(
    .ADDR_LEN   (8),
    .DATA_LEN   (8),
    .STK_DEPTH  (DEPTH),
    .MEM_RD_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .cmd_valid    (cmd_valid),
    .cmd_opc      (cmd_opc),
    .addr_const   (addr_const),
    .cmd_ready    (cmd_ready),
    .done         (done),
    .err          (err),
    .stk_count    (stk_count),
    .stk_data_out (stk_data_out),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .mem_addr     (mem_addr),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int excl_bad = 0;

  // Bench-side stack and memory that react to DUT strobes.
  logic [7:0] env_stk[$];
  logic [7:0] env_mem[256];
  logic [7:0] rd_pipe[LAT];
  // Reference model: expected architectural state.
  logic [7:0] ref_stk[$];
  logic [7:0] ref_mem[256];

  logic s_push, s_pop, s_rd, s_wr, s_done, s_ready, s_valid;
  logic [1:0] s_err;
  logic [7:0] s_sdin, s_addr, s_mdin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_env();
    stk_count    = CW'(env_stk.size());
    stk_data_out = (env_stk.size() > 0) ? env_stk[env_stk.size()-1] : 8'h00;
    mem_data_out = rd_pipe[LAT-1];
  endtask

  // Sample outputs mid-cycle, then apply their effects just after the next rising edge.
  task automatic step();
    @(negedge clk);
    s_push = stk_push; s_pop = stk_pop; s_rd = mem_r_en; s_wr = mem_w_en;
    s_done = done; s_err = err; s_ready = cmd_ready; s_valid = cmd_valid;
    s_sdin = stk_data_in; s_addr = mem_addr; s_mdin = mem_data_in;
    if ((s_push && s_pop) || (s_rd && s_wr)) excl_bad++;
    @(posedge clk);
    #1;
    if (s_push) env_stk.push_back(s_sdin);
    if (s_pop && env_stk.size() > 0) void'(env_stk.pop_back());
    if (s_wr) env_mem[s_addr] = s_mdin;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = s_rd ? env_mem[s_addr] : 8'h00;
    drive_env();
  endtask

  task automatic clear_stacks();
    env_stk.delete();
    ref_stk.delete();
    drive_env();
  endtask

  task automatic push_both(input logic [7:0] v);
    env_stk.push_back(v);
    ref_stk.push_back(v);
    drive_env();
  endtask

  task automatic cmp_stacks(input string tag);
    int mism = 0;
    chk({tag, "_depth"}, env_stk.size(), ref_stk.size());
    if (env_stk.size() == ref_stk.size())
      for (int i = 0; i < env_stk.size(); i++) if (env_stk[i] !== ref_stk[i]) mism++;
    chk({tag, "_content"}, mism, 0);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] opc, input logic [7:0] ac,
                         input bit drop_en);
    logic [1:0] e_err, o_err;
    logic [7:0] e_addr, e_data, o_addr, o_data;
    int e_lat, e_push, e_pop, e_rd, e_wr, n_push, n_pop, n_rd, n_wr, done_cyc, n;
    bit acc;
    n = ref_stk.size();
    e_push = 0; e_pop = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_data = 0; e_lat = 1;
    if (opc > 3'd4) e_err = 2'd1;
    else if (((opc == 3'd2 || opc == 3'd3) && n == 0) || (opc == 3'd4 && n < 2)) e_err = 2'd2;
    else if ((opc == 3'd0 || opc == 3'd1) && n == DEPTH) e_err = 2'd3;
    else e_err = 2'd0;
    if (e_err == 2'd0) begin
      case (opc)
        3'd0: begin e_lat = 1; e_push = 1; e_data = ac; ref_stk.push_back(ac); end
        3'd1: begin
          e_lat = LAT + 2; e_rd = 1; e_push = 1; e_addr = ac; e_data = ref_mem[ac];
          ref_stk.push_back(e_data);
        end
        3'd2: begin
          e_lat = 2; e_pop = 1; e_wr = 1; e_addr = ac; e_data = ref_stk.pop_back();
          ref_mem[e_addr] = e_data;
        end
        3'd3: begin
          e_lat = LAT + 3; e_pop = 1; e_rd = 1; e_push = 1; e_addr = ref_stk.pop_back();
          e_data = ref_mem[e_addr]; ref_stk.push_back(e_data);
        end
        default: begin
          e_lat = 3; e_pop = 2; e_wr = 1; e_addr = ref_stk.pop_back();
          e_data = ref_stk.pop_back(); ref_mem[e_addr] = e_data;
        end
      endcase
    end
    cmd_valid = 1'b1; cmd_opc = opc; addr_const = ac;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_ready && s_valid) begin acc = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    chk({tag, "_accept"}, acc, 1'b1);
    if (!acc) return;
    if (drop_en) en = 1'b0;
    n_push = 0; n_pop = 0; n_rd = 0; n_wr = 0; done_cyc = -1;
    o_err = 2'd0; o_addr = 8'h00; o_data = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (s_push) begin n_push++; o_data = s_sdin; end
      if (s_pop) n_pop++;
      if (s_rd) begin n_rd++; o_addr = s_addr; end
      if (s_wr) begin n_wr++; o_addr = s_addr; o_data = s_mdin; end
      if (s_done) begin done_cyc = c; o_err = s_err; break; end
    end
    chk({tag, "_done_cycle"}, done_cyc, e_lat);
    chk({tag, "_err"}, o_err, e_err);
    chk({tag, "_strobes"}, {n_push[3:0], n_pop[3:0], n_rd[3:0], n_wr[3:0]},
        {e_push[3:0], e_pop[3:0], e_rd[3:0], e_wr[3:0]});
    if (e_rd != 0 || e_wr != 0) chk({tag, "_addr"}, o_addr, e_addr);
    if (e_push != 0 || e_wr != 0) chk({tag, "_data"}, o_data, e_data);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_ready_after"}, cmd_ready, en);
    if (e_wr != 0) chk({tag, "_mem"}, env_mem[e_addr], ref_mem[e_addr]);
    cmp_stacks(tag);
    en = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int r, bad_ready, bad_strobe, rst_done;
    rstn = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_opc = 3'd0; addr_const = 8'h00;
    for (int i = 0; i < 256; i++) begin v = 8'($urandom); env_mem[i] = v; ref_mem[i] = v; end
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;
    drive_env();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {cmd_ready, done, err, stk_push, stk_pop, mem_r_en, mem_w_en}, 9'h0);
    chk("reset_data", {stk_data_in, mem_addr, mem_data_in}, 24'h0);
    rstn = 1'b1; en = 1'b1;
    #1;
    chk("ready_idle", cmd_ready, 1'b1);

    // Directed cases.
    for (int i = 0; i < 3; i++) push_both(8'($urandom));
    run_cmd("pushi", 3'd0, 8'h5A, 1'b0);
    env_mem[8'h10] = 8'hC3; ref_mem[8'h10] = 8'hC3;
    run_cmd("load", 3'd1, 8'h10, 1'b0);
    clear_stacks(); push_both(8'h77); push_both(8'h20);
    run_cmd("storei", 3'd4, 8'h00, 1'b0);
    clear_stacks();
    run_cmd("store_under", 3'd2, 8'h33, 1'b0);
    for (int i = 0; i < DEPTH; i++) push_both(8'($urandom));
    run_cmd("pushi_over", 3'd0, 8'h11, 1'b0);
    run_cmd("illegal", 3'd6, 8'h22, 1'b0);
    run_cmd("loadi", 3'd3, 8'h00, 1'b0);

    // en low blocks acceptance.
    en = 1'b0; cmd_valid = 1'b1; cmd_opc = 3'd0; addr_const = 8'hEE;
    bad_ready = 0; bad_strobe = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (s_ready) bad_ready++;
      if (s_push || s_pop || s_rd || s_wr || s_done) bad_strobe++;
    end
    chk("en_low_ready", bad_ready, 0);
    chk("en_low_strobes", bad_strobe, 0);
    cmd_valid = 1'b0; en = 1'b1;
    cmp_stacks("en_low");
    run_cmd("store_en_drop", 3'd2, 8'h44, 1'b1);

    // Reset during the read-wait of an indirect load.
    clear_stacks(); push_both(8'h40);
    cmd_valid = 1'b1; cmd_opc = 3'd3; addr_const = 8'h00;
    step();
    chk("rst_accept", s_ready, 1'b1);
    cmd_valid = 1'b0;
    step(); step();
    rstn = 1'b0;
    #1;
    chk("rst_strobes", {stk_push, stk_pop, mem_r_en, mem_w_en, done}, 5'h0);
    void'(ref_stk.pop_back());
    rst_done = 0;
    for (int k = 0; k < 2; k++) begin step(); if (s_done) rst_done++; end
    chk("rst_no_done", rst_done, 0);
    rstn = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    cmp_stacks("rst_stack");
    run_cmd("post_rst_pushi", 3'd0, 8'h9E, 1'b0);

    // Randomized command stream.
    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 19));
      run_cmd("rand", (r < 17) ? 3'(r % 5) : 3'(5 + r - 17), 8'($urandom),
              ($urandom_range(0, 3) == 0));
    end

    chk("strobe_exclusive", excl_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
